// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, fetch FSM encoding and reset constants.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      StIssue,
      StWait
   } fetch_state_e;

   // Force a byte address onto a word boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC, keeps one imem request in flight and presents
// {inst, pc} in a single-entry slot to decode. Redirects flush the slot and any pending fetch.
module inst_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_inst,
   output logic [XLEN-1:0] id_pc,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_q, drop_d;
   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] id_inst_q, id_inst_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic            load;

   // Next-state for FSM, PC and output slot; redirect overrides everything last.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      id_valid_d = id_valid_q;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      imem_req   = 1'b0;
      load       = 1'b0;

      unique case (state_q)
         StIssue: begin
            // Only issue when the response is guaranteed an empty slot.
            imem_req = !rst && !redirect_en && (!id_valid_q || id_ready);
            if (imem_req) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (imem_rvalid) begin
               state_d = StIssue;
               drop_d  = 1'b0;
               if (!drop_q && !redirect_en) begin
                  load = 1'b1;
                  pc_d = pc_q + XLEN'(4);
               end
            end else if (redirect_en) begin
               // Response still owed by imem; mark it stale.
               drop_d = 1'b1;
            end
         end
         default: state_d = StIssue;
      endcase

      if (load) begin
         id_valid_d = 1'b1;
         id_inst_d  = imem_rdata;
         id_pc_d    = pc_q;
      end else if (id_valid_q && id_ready) begin
         id_valid_d = 1'b0;
      end

      if (redirect_en) begin
         pc_d       = align_word(redirect_pc);
         id_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIssue;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         id_valid_q <= 1'b0;
         id_inst_q  <= NOP_INST;
         id_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         id_valid_q <= id_valid_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
      end
   end

   assign imem_addr = pc_q;
   assign id_valid  = id_valid_q;
   assign id_pc     = id_pc_q;
   assign id_inst   = id_valid_q ? id_inst_q : NOP_INST;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a variable-latency imem responder.
module tb_inst_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        redirect_en;
   logic [31:0] redirect_pc;

   int          n_chk;
   int          n_pass;
   int          mem_lat;

   localparam logic [31:0] Nop = 32'h0000_0013;

   inst_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_inst    (id_inst),
      .id_pc      (id_pc),
      .redirect_en(redirect_en),
      .redirect_pc(redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   // Imem model: samples a request mid-cycle, answers mem_lat cycles later with ~addr.
   // Cleared by rst, so no response crosses a reset.
   initial begin
      logic        pend;
      int          cnt;
      logic [31:0] paddr;
      pend        = 1'b0;
      cnt         = 0;
      paddr       = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            pend = 1'b0;
         end else if (imem_req) begin
            pend  = 1'b1;
            cnt   = mem_lat;
            paddr = imem_addr;
         end
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = ~paddr;
               pend        = 1'b0;
            end
         end
      end
   end

   // Directed stimulus; inputs change on negedge, outputs checked 1 time unit later.
   initial begin
      n_chk       = 0;
      n_pass      = 0;
      mem_lat     = 1;
      rst         = 1'b1;
      id_ready    = 1'b1;
      redirect_en = 1'b0;
      redirect_pc = '0;

      // Reset state
      nxt(); #1;
      chk("rst_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_inst", id_inst, Nop);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);

      // Streaming, 1-cycle memory
      nxt(); rst = 1'b0; #1;
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      nxt(); #1;
      chk("wait_req", {31'b0, imem_req}, 32'd0);
      chk("wait_valid", {31'b0, id_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         nxt(); #1;
         chk("st_valid", {31'b0, id_valid}, 32'd1);
         chk("st_pc", id_pc, 32'(4 * k));
         chk("st_inst", id_inst, ~32'(4 * k));
         chk("st_req", {31'b0, imem_req}, 32'd1);
         chk("st_addr", imem_addr, 32'(4 * k + 4));
         nxt(); #1;
         chk("st_gap_valid", {31'b0, id_valid}, 32'd0);
         chk("st_gap_req", {31'b0, imem_req}, 32'd0);
      end

      // Backpressure: slot must hold and no request issued
      id_ready = 1'b0;
      mem_lat  = 4;
      repeat (5) begin
         nxt(); #1;
         chk("bp_valid", {31'b0, id_valid}, 32'd1);
         chk("bp_pc", id_pc, 32'd16);
         chk("bp_inst", id_inst, ~32'd16);
         chk("bp_req", {31'b0, imem_req}, 32'd0);
      end
      nxt(); id_ready = 1'b1; #1;
      chk("bp_rel_req", {31'b0, imem_req}, 32'd1);
      chk("bp_rel_addr", imem_addr, 32'd20);

      // Redirect while waiting on a 4-cycle response
      nxt(); #1;
      chk("l4_valid", {31'b0, id_valid}, 32'd0);
      nxt(); redirect_en = 1'b1; redirect_pc = 32'h100; #1;
      chk("rdw_req", {31'b0, imem_req}, 32'd0);
      nxt(); redirect_en = 1'b0; #1;
      chk("rdw_valid1", {31'b0, id_valid}, 32'd0);
      chk("rdw_req1", {31'b0, imem_req}, 32'd0);
      nxt(); #1;
      chk("stale_valid", {31'b0, id_valid}, 32'd0);
      chk("stale_req", {31'b0, imem_req}, 32'd0);
      nxt(); #1;
      chk("post_stale_valid", {31'b0, id_valid}, 32'd0);
      chk("post_stale_inst", id_inst, Nop);
      chk("post_stale_req", {31'b0, imem_req}, 32'd1);
      chk("post_stale_addr", imem_addr, 32'h100);

      // Redirect coincident with rvalid
      repeat (3) begin
         nxt(); #1;
         chk("co_wait_valid", {31'b0, id_valid}, 32'd0);
      end
      nxt(); redirect_en = 1'b1; redirect_pc = 32'h100; mem_lat = 1; #1;
      chk("co_req", {31'b0, imem_req}, 32'd0);
      nxt(); redirect_en = 1'b0; #1;
      chk("co_valid", {31'b0, id_valid}, 32'd0);
      chk("co_req2", {31'b0, imem_req}, 32'd1);
      chk("co_addr", imem_addr, 32'h100);
      nxt(); #1;
      chk("co_wait2", {31'b0, id_valid}, 32'd0);
      nxt(); #1;
      chk("co_ld_valid", {31'b0, id_valid}, 32'd1);
      chk("co_ld_pc", id_pc, 32'h100);
      chk("co_ld_inst", id_inst, ~32'h100);
      chk("co_ld_addr", imem_addr, 32'h104);

      // Misaligned redirect target and PC wrap
      nxt(); redirect_en = 1'b1; redirect_pc = 32'h203; #1;
      chk("mis_req", {31'b0, imem_req}, 32'd0);
      nxt(); redirect_en = 1'b0; #1;
      chk("mis_valid", {31'b0, id_valid}, 32'd0);
      chk("mis_req2", {31'b0, imem_req}, 32'd1);
      chk("mis_addr", imem_addr, 32'h200);
      nxt(); #1;
      chk("mis_wait", {31'b0, id_valid}, 32'd0);
      nxt(); redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
      chk("flush_valid_now", {31'b0, id_valid}, 32'd1);
      chk("flush_pc_now", id_pc, 32'h200);
      chk("flush_req", {31'b0, imem_req}, 32'd0);
      nxt(); redirect_en = 1'b0; #1;
      chk("flush_valid", {31'b0, id_valid}, 32'd0);
      chk("top_req", {31'b0, imem_req}, 32'd1);
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      nxt(); #1;
      chk("top_wait", {31'b0, id_valid}, 32'd0);
      nxt(); mem_lat = 4; #1;
      chk("top_valid", {31'b0, id_valid}, 32'd1);
      chk("top_pc", id_pc, 32'hFFFF_FFFC);
      chk("top_inst", id_inst, 32'h0000_0003);
      chk("wrap_req", {31'b0, imem_req}, 32'd1);
      chk("wrap_addr", imem_addr, 32'h0);

      // Reset with a fetch outstanding
      nxt(); #1;
      chk("r6_wait", {31'b0, id_valid}, 32'd0);
      nxt(); rst = 1'b1; #1;
      chk("r6_req_gated", {31'b0, imem_req}, 32'd0);
      nxt(); #1;
      chk("r6_valid", {31'b0, id_valid}, 32'd0);
      chk("r6_inst", id_inst, Nop);
      chk("r6_pc", id_pc, 32'd0);
      chk("r6_addr", imem_addr, 32'd0);
      chk("r6_req", {31'b0, imem_req}, 32'd0);
      nxt(); rst = 1'b0; #1;
      chk("r6_req2", {31'b0, imem_req}, 32'd1);
      chk("r6_addr2", imem_addr, 32'd0);
      repeat (4) begin
         nxt(); #1;
         chk("r6_no_stale", {31'b0, id_valid}, 32'd0);
      end
      nxt(); id_ready = 1'b0; #1;
      chk("r6_ld_valid", {31'b0, id_valid}, 32'd1);
      chk("r6_ld_pc", id_pc, 32'd0);
      chk("r6_ld_inst", id_inst, 32'hFFFF_FFFF);
      chk("r6_hold_req", {31'b0, imem_req}, 32'd0);

      // Reset while the slot is full
      rst = 1'b1; #1;
      chk("r7_req", {31'b0, imem_req}, 32'd0);
      nxt(); #1;
      chk("r7_valid", {31'b0, id_valid}, 32'd0);
      chk("r7_inst", id_inst, Nop);
      chk("r7_pc", id_pc, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
